// File: rtl/pb_gpio_pkg.sv
// rtl/pb_gpio_pkg.sv - register map and sizing helpers for the Picoblaze GPIO port
package pb_gpio_pkg;

  typedef enum logic [1:0] {
    REG_LED_DATA    = 2'd0,
    REG_SW_STATE    = 2'd1,
    REG_EDGE_STATUS = 2'd2,
    REG_IRQ_ENABLE  = 2'd3
  } reg_e;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pb_gpio_if.sv
// rtl/pb_gpio_if.sv - Picoblaze I/O port bus as seen by one peripheral
interface pb_gpio_if;
  logic [7:0] PORT_ID;
  logic       WRITE_STROBE;
  logic       READ_STROBE;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_PORT;
  logic       INTERRUPT;

  modport master (
    output PORT_ID, WRITE_STROBE, READ_STROBE, OUT_PORT,
    input  IN_PORT, INTERRUPT
  );

  modport slave (
    input  PORT_ID, WRITE_STROBE, READ_STROBE, OUT_PORT,
    output IN_PORT, INTERRUPT
  );
endinterface

// File: rtl/pb_gpio_debounce.sv
// rtl/pb_gpio_debounce.sv - one switch bit: 2-flop synchroniser, stability counter,
// debounced level and single-cycle rise/fall pulses aligned with the level change
module pb_gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic rise,
  output logic fall
);
  import pb_gpio_pkg::*;

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      state <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_gpio_port.sv
// rtl/pb_gpio_port.sv - LED/switch GPIO bank on the Picoblaze port bus with edge interrupt;
// define GPIO_BOTH_EDGES_EN to also latch falling debounced edges
module pb_gpio_port #(
  parameter int         WIDTH           = 8,
  parameter logic [7:0] BASE_ADDR       = 8'h00,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK_IN,
  input  logic             RESET_N_IN,
  pb_gpio_if.slave         bus,
  input  logic [WIDTH-1:0] SWITCHES,
  output logic [WIDTH-1:0] LEDS
);
  import pb_gpio_pkg::*;

  localparam int NBYTES = nbytes(WIDTH);

  logic             hit;
  logic             wr_en;
  logic [1:0]       lane;
  reg_e             rsel;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] led_data;
  logic [WIDTH-1:0] edge_status;
  logic [WIDTH-1:0] irq_enable;
  logic [WIDTH-1:0] sw_state;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] rd_src;
  logic [NBYTES-1:0][7:0] rd_bytes;
  logic [NBYTES:0][7:0]   rd_acc;
  logic [7:0]       in_port;
  logic             interrupt;

  assign hit   = (bus.PORT_ID[7:4] == BASE_ADDR[7:4]);
  assign rsel  = reg_e'(bus.PORT_ID[3:2]);
  assign lane  = bus.PORT_ID[1:0];
  assign wr_en = hit & bus.WRITE_STROBE;

  // Lanes beyond NBYTES own no bits, so their writes fall away and reads yield zero.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign lane_mask[i] = (lane == 2'(i / 8));
    assign wdata[i]     = bus.OUT_PORT[i % 8];

    pb_gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (CLK_IN),
      .rst_n (RESET_N_IN),
      .pin   (SWITCHES[i]),
      .state (sw_state[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  assign w1c_mask = (wr_en && rsel == REG_EDGE_STATUS) ? (lane_mask & wdata) : '0;

`ifdef GPIO_BOTH_EDGES_EN
  assign edge_set = sw_rise | sw_fall;
  logic unused_inputs;
  assign unused_inputs = bus.READ_STROBE;
`else
  assign edge_set = sw_rise;
  logic unused_inputs;
  assign unused_inputs = ^{bus.READ_STROBE, sw_fall};
`endif

  always_comb begin
    rd_src = '0;
    unique case (rsel)
      REG_LED_DATA:    rd_src = led_data;
      REG_SW_STATE:    rd_src = sw_state;
      REG_EDGE_STATUS: rd_src = edge_status;
      REG_IRQ_ENABLE:  rd_src = irq_enable;
      default:         rd_src = '0;
    endcase
  end

  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    for (genvar k = 0; k < 8; k++) begin : g_lane_bit
      if (b * 8 + k < WIDTH) begin : g_used
        assign rd_bytes[b][k] = rd_src[b*8+k];
      end else begin : g_pad
        assign rd_bytes[b][k] = 1'b0;
      end
    end
    assign rd_acc[b+1] = rd_acc[b] | ({8{lane == 2'(b)}} & rd_bytes[b]);
  end
  assign rd_acc[0] = '0;

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      led_data    <= '0;
      irq_enable  <= '0;
      edge_status <= '0;
      in_port     <= 8'h00;
      interrupt   <= 1'b0;
    end else begin
      if (wr_en && rsel == REG_LED_DATA)
        led_data <= (led_data & ~lane_mask) | (wdata & lane_mask);
      if (wr_en && rsel == REG_IRQ_ENABLE)
        irq_enable <= (irq_enable & ~lane_mask) | (wdata & lane_mask);
      // A new edge overrides a simultaneous clear of the same bit.
      edge_status <= (edge_status & ~w1c_mask) | edge_set;
      in_port     <= hit ? rd_acc[NBYTES] : 8'h00;
      interrupt   <= |(edge_status & irq_enable);
    end
  end

  assign LEDS          = led_data;
  assign bus.IN_PORT   = in_port;
  assign bus.INTERRUPT = interrupt;

endmodule
